// File: rtl/xgmii_pkg.sv
// Purpose: shared XGMII control characters, receive FSM states and lane helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] XGMII_ERROR = 8'hFE;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        TAIL
    } rx_state_t;

    // Lowest lane with its control flag set; 8 means the whole word is data.
    function automatic logic [3:0] first_ctrl_lane(input logic [7:0] c);
        logic [3:0] lane;
        lane = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (c[i]) lane = 4'(i);
        end
        return lane;
    endfunction

    // Byte enables for the k-1 payload bytes that sit in lanes 1..k-1.
    function automatic logic [7:0] keep_below(input logic [3:0] k);
        logic [7:0] one_hot;
        one_hot = 8'd1 << (k - 4'd1);
        return one_hot - 8'd1;
    endfunction

endpackage

// File: rtl/xgmii_lane_decode.sv
// Purpose: per-word XGMII lane decode: first control lane, terminate check, trailing error.
// Latency: purely combinational.
// Backpressure: none; evaluates every word.
module xgmii_lane_decode
    import xgmii_pkg::*;
(
    input  logic [63:0] d,
    input  logic [7:0]  c,
    input  logic        skip0,
    output logic [3:0]  k,
    output logic        is_term,
    output logic        err_any
);

    logic [7:0] c_eff;

    // Outside a frame lane 0 carries the start character, so it is excluded from k.
    always_comb begin
        c_eff    = c;
        c_eff[0] = c[0] & ~skip0;
        k        = first_ctrl_lane(c_eff);
        is_term  = 1'b0;
        err_any  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) == k && d[8*i +: 8] == XGMII_TERM) is_term = 1'b1;
            if (4'(i) > k && c[i] && d[8*i +: 8] == XGMII_ERROR) err_any = 1'b1;
        end
    end

endmodule

// File: rtl/xgmii_to_axis.sv
// Purpose: XGMII RX framer, realigns lane-1 payload into 64-bit AXI-Stream beats.
// Latency: one cycle from the completing XGMII word to the registered beat.
// Backpressure: none; downstream must accept every beat (no tready).
module xgmii_to_axis #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [63:0]      xgmii_d,
    input  logic [7:0]       xgmii_c,
    output logic [63:0]      maxis_tdata,
    output logic             maxis_tvalid,
    output logic [7:0]       maxis_tkeep,
    output logic             maxis_tlast,
    output logic             maxis_tuser,
    output logic [CNT_W-1:0] rx_frames,
    output logic [CNT_W-1:0] rx_errors
);
    import xgmii_pkg::*;

    rx_state_t   state;
    logic [55:0] carry;
    logic [55:0] tail_dat;
    logic [7:0]  tail_keep;
    logic        tail_user;
    logic        err_seen;

    logic        skip0;
    logic [3:0]  k;
    logic        is_term;
    logic        err_any;
    logic        is_start;
    logic        k_mid;
    logic        start_err;
    logic        end_err;
    logic        payload_fe;
    logic [7:0]  part_keep;
    logic [55:0] part_dat;
    logic        frame_inc;
    logic [1:0]  err_inc;

    xgmii_lane_decode u_dec (
        .d       (xgmii_d),
        .c       (xgmii_c),
        .skip0   (skip0),
        .k       (k),
        .is_term (is_term),
        .err_any (err_any)
    );

    // Word classification and the partial payload of lanes 1..k-1.
    always_comb begin
        skip0     = (state != DATA);
        is_start  = xgmii_c[0] && (xgmii_d[7:0] == XGMII_START);
        k_mid     = (k >= 4'd2) && (k <= 4'd7);
        part_keep = keep_below(k);
        part_dat  = '0;
        for (int i = 0; i < 7; i++) begin
            part_dat[8*i +: 8] = xgmii_d[8*i+8 +: 8] & {8{part_keep[i]}};
        end
        payload_fe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < k && xgmii_d[8*i +: 8] == XGMII_ERROR) payload_fe = 1'b1;
        end
        start_err = !is_term || err_any;
        end_err   = start_err || err_seen || payload_fe;
    end

    // Counter increments, aligned with the cycle the tlast beat is registered.
    always_comb begin
        frame_inc = 1'b0;
        err_inc   = 2'd0;
        case (state)
            IDLE: begin
                if (is_start && k_mid) begin
                    frame_inc = 1'b1;
                    err_inc   = {1'b0, start_err};
                end
            end
            DATA: begin
                if (k <= 4'd1) begin
                    frame_inc = 1'b1;
                    err_inc   = {1'b0, end_err};
                end
            end
            TAIL: begin
                // A start+terminate word here is dropped and charged as an error.
                frame_inc = 1'b1;
                err_inc   = {1'b0, tail_user} + {1'b0, is_start && k_mid};
            end
            default: begin
                frame_inc = 1'b0;
            end
        endcase
    end

    // Receive FSM with registered AXI-Stream outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            carry        <= '0;
            tail_dat     <= '0;
            tail_keep    <= '0;
            tail_user    <= 1'b0;
            err_seen     <= 1'b0;
            maxis_tvalid <= 1'b0;
            maxis_tdata  <= '0;
            maxis_tkeep  <= '0;
            maxis_tlast  <= 1'b0;
            maxis_tuser  <= 1'b0;
        end else begin
            maxis_tvalid <= 1'b0;
            maxis_tdata  <= '0;
            maxis_tkeep  <= '0;
            maxis_tlast  <= 1'b0;
            maxis_tuser  <= 1'b0;
            case (state)
                DATA: begin
                    maxis_tvalid <= 1'b1;
                    maxis_tdata  <= {xgmii_d[7:0], carry};
                    maxis_tkeep  <= 8'hFF;
                    if (k == 4'd8) begin
                        carry    <= xgmii_d[63:8];
                        err_seen <= err_seen | payload_fe;
                    end else if (k <= 4'd1) begin
                        maxis_tlast <= 1'b1;
                        maxis_tuser <= end_err;
                        state       <= IDLE;
                        if (k == 4'd0) begin
                            maxis_tdata <= {8'h00, carry};
                            maxis_tkeep <= 8'h7F;
                        end
                    end else begin
                        tail_dat  <= part_dat;
                        tail_keep <= part_keep;
                        tail_user <= end_err;
                        state     <= TAIL;
                    end
                end
                default: begin
                    // IDLE and TAIL look for a start the same way; TAIL also flushes the tail.
                    state <= IDLE;
                    if (state == TAIL) begin
                        maxis_tvalid <= 1'b1;
                        maxis_tdata  <= {8'h00, tail_dat};
                        maxis_tkeep  <= tail_keep;
                        maxis_tlast  <= 1'b1;
                        maxis_tuser  <= tail_user;
                    end
                    if (is_start) begin
                        err_seen <= 1'b0;
                        if (k == 4'd8) begin
                            carry <= xgmii_d[63:8];
                            state <= DATA;
                        end else if (k_mid && state == IDLE) begin
                            maxis_tvalid <= 1'b1;
                            maxis_tdata  <= {8'h00, part_dat};
                            maxis_tkeep  <= part_keep;
                            maxis_tlast  <= 1'b1;
                            maxis_tuser  <= start_err;
                        end
                    end
                end
            endcase
        end
    end

    // Frame and error statistics, wrapping at 2^CNT_W.
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_frames <= '0;
            rx_errors <= '0;
        end else begin
            rx_frames <= rx_frames + CNT_W'(frame_inc);
            rx_errors <= rx_errors + CNT_W'(err_inc);
        end
    end

endmodule

// File: tb/tb_xgmii_to_axis.sv
// Purpose: self-checking bench for the XGMII RX framer (vector table plus corner sequences).
// Latency: expects each beat on the cycle after its completing word.
// Backpressure: none exercised; the DUT has no tready.
module tb_xgmii_to_axis;

    typedef struct packed {
        logic [63:0] dat;
        logic [7:0]  keep;
        logic        last;
        logic        user;
    } beat_t;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  c;
        logic        vld;
        beat_t       exp;
    } vec_t;

    localparam logic [63:0] IDLEW = 64'h0707070707070707;
    localparam logic [63:0] S1    = 64'h06050403020100FB;
    localparam logic [63:0] S2    = 64'h26252423222120FB;
    localparam logic [63:0] W2    = 64'h0E0D0C0B0A090807;
    localparam logic [63:0] T3    = 64'h07070707FD0A0908;
    localparam logic [63:0] ST4   = 64'h070707FD121110FB;
    localparam logic [63:0] T0    = 64'h07070707070707FD;

    logic        clock;
    logic        reset;
    logic [63:0] xgmii_d;
    logic [7:0]  xgmii_c;
    logic [63:0] maxis_tdata;
    logic        maxis_tvalid;
    logic [7:0]  maxis_tkeep;
    logic        maxis_tlast;
    logic        maxis_tuser;
    logic [31:0] rx_frames;
    logic [31:0] rx_errors;

    int    checks;
    int    errors;
    int    exp_frames;
    int    exp_errors;
    beat_t exp_q[$];
    vec_t  tbl[0:15];

    xgmii_to_axis #(.CNT_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .xgmii_d      (xgmii_d),
        .xgmii_c      (xgmii_c),
        .maxis_tdata  (maxis_tdata),
        .maxis_tvalid (maxis_tvalid),
        .maxis_tkeep  (maxis_tkeep),
        .maxis_tlast  (maxis_tlast),
        .maxis_tuser  (maxis_tuser),
        .rx_frames    (rx_frames),
        .rx_errors    (rx_errors)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic beat_t mkb(input logic [63:0] dat, input logic [7:0] keep,
                                  input logic last, input logic user);
        beat_t b;
        b.dat = dat; b.keep = keep; b.last = last; b.user = user;
        return b;
    endfunction

    function automatic vec_t mkv(input logic [63:0] d, input logic [7:0] c,
                                 input logic vld, input beat_t exp);
        vec_t v;
        v.d = d; v.c = c; v.vld = vld; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Compare whatever the DUT produced for the previous word against the scoreboard.
    task automatic sample_outputs();
        beat_t b;
        if (maxis_tvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got tdata=%h tkeep=%h tlast=%b, required no beat",
                         maxis_tdata, maxis_tkeep, maxis_tlast);
            end else begin
                b = exp_q.pop_front();
                chk("beat", {maxis_tdata, maxis_tkeep, maxis_tlast, maxis_tuser, 6'd0},
                    {b.dat, b.keep, b.last, b.user, 6'd0});
            end
        end
    endtask

    // One XGMII word: check last cycle's output, drive the word, record what it must produce.
    task automatic cycle(input logic [63:0] d, input logic [7:0] c, input logic vld, input beat_t exp);
        @(negedge clock);
        sample_outputs();
        xgmii_d = d;
        xgmii_c = c;
        if (vld) begin
            exp_q.push_back(exp);
            if (exp.last) begin
                exp_frames++;
                if (exp.user) exp_errors++;
            end
        end
    endtask

    task automatic idle_word();
        cycle(IDLEW, 8'hFF, 1'b0, '0);
    endtask

    // Bounded drain, then check the statistics counters.
    task automatic checkpoint(input string name);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) idle_word();
        idle_word();
        chk({name, "_drained"}, 80'(exp_q.size()), 80'd0);
        chk({name, "_rx_frames"}, 80'(rx_frames), 80'(exp_frames));
        chk({name, "_rx_errors"}, 80'(rx_errors), 80'(exp_errors));
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        exp_frames = 0;
        exp_errors = 0;
        reset      = 1'b1;
        xgmii_d    = IDLEW;
        xgmii_c    = 8'hFF;

        tbl[0]  = mkv(S1,                    8'h01, 1'b0, '0);
        tbl[1]  = mkv(64'h070707070707FD07,  8'hFE, 1'b1, mkb(64'h0706050403020100, 8'hFF, 1'b1, 1'b0));
        tbl[2]  = mkv(S1,                    8'h01, 1'b0, '0);
        tbl[3]  = mkv(W2,                    8'h00, 1'b1, mkb(64'h0706050403020100, 8'hFF, 1'b0, 1'b0));
        tbl[4]  = mkv(64'hFD0D0C0B0A090807,  8'h80, 1'b1, mkb(64'h070E0D0C0B0A0908, 8'hFF, 1'b0, 1'b0));
        tbl[5]  = mkv(IDLEW,                 8'hFF, 1'b1, mkb(64'h00000D0C0B0A0908, 8'h3F, 1'b1, 1'b0));
        tbl[6]  = mkv(S1,                    8'h01, 1'b0, '0);
        tbl[7]  = mkv(64'h07070707070707FE,  8'hFF, 1'b1, mkb(64'h0006050403020100, 8'h7F, 1'b1, 1'b1));
        tbl[8]  = mkv(ST4,                   8'hF1, 1'b1, mkb(64'h0000000000121110, 8'h07, 1'b1, 1'b0));
        tbl[9]  = mkv(64'h070707070707FDFB,  8'hFF, 1'b0, '0);
        tbl[10] = mkv(64'h07070707FB070707,  8'hFF, 1'b0, '0);
        tbl[11] = mkv(S1,                    8'h01, 1'b0, '0);
        tbl[12] = mkv(64'h0707FE07FD0A0908,  8'hF8, 1'b1, mkb(64'h0806050403020100, 8'hFF, 1'b0, 1'b0));
        tbl[13] = mkv(IDLEW,                 8'hFF, 1'b1, mkb(64'h0000000000000A09, 8'h03, 1'b1, 1'b1));
        tbl[14] = mkv(64'h07070707FE1110FB,  8'hF9, 1'b1, mkb(64'h0000000000001110, 8'h03, 1'b1, 1'b1));
        tbl[15] = mkv(IDLEW,                 8'hFF, 1'b0, '0);

        // Reset state
        repeat (3) @(negedge clock);
        chk("reset_tvalid", 80'(maxis_tvalid), 80'd0);
        chk("reset_tdata",  80'(maxis_tdata),  80'd0);
        chk("reset_tkeep",  80'(maxis_tkeep),  80'd0);
        chk("reset_tlast",  80'(maxis_tlast),  80'd0);
        chk("reset_frames", 80'(rx_frames),    80'd0);
        chk("reset_errors", 80'(rx_errors),    80'd0);
        reset = 1'b0;

        // Idle stream produces nothing
        repeat (10) idle_word();
        checkpoint("idle");

        // Vector table
        for (int i = 0; i < 16; i++) cycle(tbl[i].d, tbl[i].c, tbl[i].vld, tbl[i].exp);
        checkpoint("table");

        // Terminate at k=3 followed immediately by a new start
        cycle(S1, 8'h01, 1'b0, '0);
        cycle(T3, 8'hF8, 1'b1, mkb(64'h0806050403020100, 8'hFF, 1'b0, 1'b0));
        cycle(S2, 8'h01, 1'b1, mkb(64'h0000000000000A09, 8'h03, 1'b1, 1'b0));
        cycle(T0, 8'hFF, 1'b1, mkb(64'h0026252423222120, 8'h7F, 1'b1, 1'b0));
        checkpoint("tail_then_start");

        // Start+terminate word during the tail cycle is dropped and counted as an error
        cycle(S1, 8'h01, 1'b0, '0);
        cycle(T3, 8'hF8, 1'b1, mkb(64'h0806050403020100, 8'hFF, 1'b0, 1'b0));
        cycle(ST4, 8'hF1, 1'b1, mkb(64'h0000000000000A09, 8'h03, 1'b1, 1'b0));
        exp_errors++;
        checkpoint("tail_drop");

        // Reset in mid-frame after two beats
        cycle(S1, 8'h01, 1'b0, '0);
        cycle(W2, 8'h00, 1'b1, mkb(64'h0706050403020100, 8'hFF, 1'b0, 1'b0));
        cycle(W2, 8'h00, 1'b1, mkb(64'h070E0D0C0B0A0908, 8'hFF, 1'b0, 1'b0));
        @(negedge clock);
        sample_outputs();
        reset   = 1'b1;
        xgmii_d = W2;
        xgmii_c = 8'h00;
        @(negedge clock);
        chk("midreset_tvalid", 80'(maxis_tvalid), 80'd0);
        chk("midreset_tlast",  80'(maxis_tlast),  80'd0);
        chk("midreset_tdata",  80'(maxis_tdata),  80'd0);
        chk("midreset_frames", 80'(rx_frames),    80'd0);
        chk("midreset_errors", 80'(rx_errors),    80'd0);
        reset      = 1'b0;
        exp_frames = 0;
        exp_errors = 0;
        xgmii_d    = IDLEW;
        xgmii_c    = 8'hFF;
        idle_word();
        cycle(S1, 8'h01, 1'b0, '0);
        cycle(64'h070707070707FD07, 8'hFE, 1'b1, mkb(64'h0706050403020100, 8'hFF, 1'b1, 1'b0));
        checkpoint("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
